clk_gen_ctrl: RTL and testbench

- Synthesizable programmable clock generator and sequencer with run-time period and duty-cycle control.
- Produces a divided clock `clk_out` from the system clock. LOW and HIGH phase lengths are set in system-clock cycles.
- Generates either a bounded burst of N periods or runs free.
- Sits between the register/config interface and any block that needs a gated, programmable-duty clock or clock-enable.

---
 rtl/clk_gen_pkg.sv | 19 +
 rtl/clk_gen_ctrl_phase_counter.sv | 27 ++
 rtl/clk_gen_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clk_gen_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the programmable clock generator.
// State encoding, default widths and the zero-length clamp live here.
package clk_gen_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    // A zero-length phase would stall the generator, so zero is treated as one.
    function automatic logic [31:0] clamp_nz(input logic [31:0] v);
        return (v == '0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/clk_gen_ctrl_phase_counter.sv
// Loadable down-counter that holds at zero; the zero flag marks the last
// cycle of the current phase.
module phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock generator: LOW/HIGH phase lengths, burst or free-run,
// shadowed live reconfiguration and graceful stop at the end of a HIGH phase.
module clk_gen_ctrl
    import clk_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [CNT_W-1:0]   cfg_low,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clk_out,
    output logic               rise_pulse,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
);

    state_t             state;
    logic [CNT_W-1:0]   act_high, act_low, sh_high, sh_low;
    logic [BURST_W-1:0] act_burst, sh_burst;
    logic               sh_valid, stop_pend;

    logic [CNT_W-1:0]   in_high, in_low;
    logic [BURST_W-1:0] pc_plus1, pc_sat;
    logic               cfg_fire, start_ok, period_end, run_end;
    logic               cnt_zero, cnt_load;
    logic [CNT_W-1:0]   cnt_val;

    assign busy      = (state != IDLE);
    assign cfg_ready = (state == IDLE) || !sh_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_high   = CNT_W'(clamp_nz(32'(cfg_high)));
    assign in_low    = CNT_W'(clamp_nz(32'(cfg_low)));
    assign start_ok  = (state == IDLE) && start && !stop;

    assign pc_plus1   = period_cnt + 1'b1;
    assign pc_sat     = (period_cnt == '1) ? period_cnt : pc_plus1;
    assign period_end = (state == HIGH) && cnt_zero;
    assign run_end    = period_end &&
                        (stop_pend || ((act_burst != '0) && (pc_plus1 == act_burst)));

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    cnt_load = 1'b1;
                    cnt_val  = (cfg_fire ? in_low : act_low) - 1'b1;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = act_high - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_zero && !run_end) begin
                    cnt_load = 1'b1;
                    cnt_val  = (sh_valid ? sh_low : act_low) - 1'b1;
                end
            end
            default: ;
        endcase
    end

    phase_counter #(.W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            done       <= 1'b0;
            period_cnt <= '0;
            act_high   <= CNT_W'(1);
            act_low    <= CNT_W'(1);
            act_burst  <= '0;
            sh_high    <= '0;
            sh_low     <= '0;
            sh_burst   <= '0;
            sh_valid   <= 1'b0;
            stop_pend  <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= LOW;
                        period_cnt <= '0;
                    end
                end
                LOW: begin
                    if (cnt_zero) begin
                        state      <= HIGH;
                        clk_out    <= 1'b1;
                        rise_pulse <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        clk_out    <= 1'b0;
                        period_cnt <= pc_sat;
                        if (run_end) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == IDLE) begin
                if (cfg_fire) begin
                    act_high  <= in_high;
                    act_low   <= in_low;
                    act_burst <= cfg_burst;
                end
            end else if (run_end) begin
                // A config caught at run end goes straight to the active set so it is not stranded.
                sh_valid  <= 1'b0;
                stop_pend <= 1'b0;
                if (cfg_fire) begin
                    act_high  <= in_high;
                    act_low   <= in_low;
                    act_burst <= cfg_burst;
                end else if (sh_valid) begin
                    act_high  <= sh_high;
                    act_low   <= sh_low;
                    act_burst <= sh_burst;
                end
            end else begin
                if (period_end && sh_valid) begin
                    act_high  <= sh_high;
                    act_low   <= sh_low;
                    act_burst <= sh_burst;
                    sh_valid  <= 1'b0;
                end
                if (cfg_fire) begin
                    sh_high  <= in_high;
                    sh_low   <= in_low;
                    sh_burst <= cfg_burst;
                    sh_valid <= 1'b1;
                end
                if (stop) begin
                    stop_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Scoreboard bench for clk_gen_ctrl: expected per-cycle clk_out/rise/busy/done
// values are queued as stimulus is driven and popped on every falling edge.
module tb_clk_gen_ctrl;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_high, cfg_low;
    logic [BURST_W-1:0] cfg_burst;
    logic               start, stop;
    logic               clk_out, rise_pulse, busy, done;
    logic [BURST_W-1:0] period_cnt;

    typedef struct packed {
        logic clk_o;
        logic rise;
        logic bsy;
        logic dn;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    clk_gen_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_clk_out", 32'(clk_out),    32'(e.clk_o));
            chk("sb_rise",    32'(rise_pulse), 32'(e.rise));
            chk("sb_busy",    32'(busy),       32'(e.bsy));
            chk("sb_done",    32'(done),       32'(e.dn));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic c, input logic r, input logic b, input logic d);
        exp_t e;
        e = '{clk_o: c, rise: r, bsy: b, dn: d};
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_period(input int lo, input int hi);
        push_n(lo, 1'b0, 1'b0, 1'b1, 1'b0);
        push_n(1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_n(hi - 1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_end(input int idles);
        push_n(1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_n(idles, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic set_cfg(input int h, input int l, input int b);
        cfg_high  = CNT_W'(h);
        cfg_low   = CNT_W'(l);
        cfg_burst = BURST_W'(b);
        cfg_valid = 1'b1;
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_high = '0; cfg_low = '0; cfg_burst = '0;
        start = 1'b0; stop = 1'b0;
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_rise",    32'(rise_pulse), 32'd0);
        chk("rst_pcnt",    32'(period_cnt), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("rel_cfg_ready", 32'(cfg_ready), 32'd1);

        // Free-run duty 4 low / 6 high, then stop on the last HIGH cycle of period 3
        set_cfg(6, 4, 0);
        start = 1'b1;
        for (int p = 0; p < 3; p++) push_period(4, 6);
        step();
        start = 1'b0;
        wait_drain(60);
        stop = 1'b1;
        push_period(4, 6);
        push_end(1);
        step();
        stop = 1'b0;
        wait_drain(40);

        // Burst of 4 periods, 3 low / 2 high
        set_cfg(2, 3, 4);
        start = 1'b1;
        for (int p = 0; p < 4; p++) push_period(3, 2);
        push_end(2);
        step();
        start = 1'b0;
        wait_drain(60);
        chk("burst_pcnt", 32'(period_cnt), 32'd4);
        chk("burst_busy", 32'(busy), 32'd0);

        // Graceful stop during the 2nd HIGH cycle: HIGH still runs its full 5 cycles
        set_cfg(5, 5, 0);
        start = 1'b1;
        push_period(5, 5);
        push_period(5, 2);
        step();
        start = 1'b0;
        wait_drain(60);
        stop = 1'b1;
        push_n(3, 1'b1, 1'b0, 1'b1, 1'b0);
        push_end(3);
        step();
        stop = 1'b0;
        wait_drain(40);

        // Live reconfig: 4/4 running, shadow 1/2 swaps in at period end, second cfg stalls
        set_cfg(4, 4, 0);
        start = 1'b1;
        push_period(4, 4);
        push_period(2, 1);
        push_period(3, 3);
        push_end(2);
        step();
        start = 1'b0;
        cfg_high = CNT_W'(1); cfg_low = CNT_W'(2); cfg_burst = '0; cfg_valid = 1'b1;
        chk("ready_shadow_empty", 32'(cfg_ready), 32'd1);
        step();
        cfg_high = CNT_W'(3); cfg_low = CNT_W'(3);
        for (int i = 0; i < 7; i++) begin
            chk("ready_shadow_full", 32'(cfg_ready), 32'd0);
            step();
        end
        chk("ready_after_swap", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        step(); step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_drain(60);

        // Zero lengths clamp to 1; cfg and start share a cycle; start on the done cycle is ignored
        cfg_high = '0; cfg_low = '0; cfg_burst = BURST_W'(2); cfg_valid = 1'b1;
        start = 1'b1;
        push_period(1, 1);
        push_period(1, 1);
        push_end(3);
        step();
        start = 1'b0; cfg_valid = 1'b0;
        step(); step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_drain(20);
        chk("clamp_pcnt", 32'(period_cnt), 32'd2);

        // start && stop together in IDLE
        push_n(3, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        wait_drain(20);
        chk("startstop_busy", 32'(busy), 32'd0);

        // Async reset mid-HIGH
        set_cfg(5, 5, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (clk_out !== 1'b1 && n < 50) begin
                step();
                n++;
            end
        end
        chk("arst_reach_high", 32'(clk_out), 32'd1);
        step(); step();
        rst = 1'b1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_rise",    32'(rise_pulse), 32'd0);
        chk("arst_done",    32'(done),    32'd0);
        chk("arst_pcnt",    32'(period_cnt), 32'd0);
        step();
        chk("arst_hold_low", 32'(clk_out), 32'd0);
        rst = 1'b0;
        step();
        chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
